// File: rtl/io_bus_if.sv
// 16-bit external I/O bus between the bus bridge (master) and a responder (slave).
// Carries request, write data, read data, acknowledge and the level interrupt.
interface io_bus_if;
    logic        io_bus_enable;
    logic        io_rw;
    logic [15:0] io_address;
    logic [1:0]  io_byte_enable;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;

    modport master (
        output io_bus_enable,
        output io_rw,
        output io_address,
        output io_byte_enable,
        output io_write_data,
        input  io_read_data,
        input  io_acknowledge,
        input  io_irq
    );

    modport slave (
        input  io_bus_enable,
        input  io_rw,
        input  io_address,
        input  io_byte_enable,
        input  io_write_data,
        output io_read_data,
        output io_acknowledge,
        output io_irq
    );
endinterface

// File: rtl/io_bus_responder.sv
// I/O bus responder: 4-register window with scratch, loopback FIFO, status/W1C flags and
// a level interrupt; programmable wait states and a single-cycle acknowledge.
module io_bus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic     clk,
    input logic     reset,
    io_bus_if.slave io_bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    localparam logic [1:0] RegScratch = 2'd0;
    localparam logic [1:0] RegFifo    = 2'd1;
    localparam logic [1:0] RegStatus  = 2'd2;
    localparam logic [1:0] RegIrqCtrl = 2'd3;

    typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

    state_e          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic            rw_q;
    logic [1:0]      sel_q;
    logic [1:0]      be_q;
    logic [15:0]     wdata_q;
    logic [15:0]     scratch_q, scratch_d;
    logic [1:0]      irq_ctrl_q, irq_ctrl_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     rdata_q, rdata_d;
    logic            irq_q, irq_d;

    logic            hit, accept;
    logic            ack, wr_en, rd_en, push;
    logic            eff_rw;
    logic [1:0]      eff_sel;
    logic            empty, full;
    logic [15:0]     status_word, rdata_mux;

    assign hit         = io_bus.io_bus_enable && (io_bus.io_address[15:3] == BASE_ADDR[15:3]);
    assign accept      = (state_q == StIdle) && hit;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CntFull);
    assign status_word = {7'd0, unf_q, ovf_q, full, empty, 5'(count_q)};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    wait_d  = WaitInit;
                    state_d = (WAIT_STATES == 0) ? StAck : StWait;
                end
            end
            StWait: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    state_d = StAck;
                end
            end
            StAck: state_d = StHold;
            StHold: begin
                if (!io_bus.io_bus_enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: side effects are confined to the acknowledge cycle
    always_comb begin
        ack   = (state_q == StAck);
        wr_en = ack && !rw_q;
        rd_en = ack && rw_q;
    end

    assign io_bus.io_acknowledge = ack;
    assign io_bus.io_read_data   = rdata_q;
    assign io_bus.io_irq         = irq_q;

    // With zero wait states the request goes straight from IDLE to ACK, so use it unlatched.
    assign eff_rw  = (state_q == StIdle) ? io_bus.io_rw : rw_q;
    assign eff_sel = (state_q == StIdle) ? io_bus.io_address[2:1] : sel_q;

    // Read data is loaded on entry to ACK, so it shows the pre-access register state.
    always_comb begin
        rdata_mux = '0;
        unique case (eff_sel)
            RegScratch: rdata_mux = scratch_q;
            RegFifo:    rdata_mux = empty ? 16'h0000 : mem_q[rd_ptr_q];
            RegStatus:  rdata_mux = status_word;
            RegIrqCtrl: rdata_mux = {14'd0, irq_ctrl_q};
        endcase
        rdata_d = ((state_d == StAck) && eff_rw) ? rdata_mux : rdata_q;
    end

    always_comb begin
        scratch_d  = scratch_q;
        irq_ctrl_d = irq_ctrl_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        if (wr_en) begin
            unique case (sel_q)
                RegScratch: begin
                    if (be_q[0]) scratch_d[7:0]  = wdata_q[7:0];
                    if (be_q[1]) scratch_d[15:8] = wdata_q[15:8];
                end
                RegFifo: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                        count_d  = count_q + CntW'(1);
                    end
                end
                RegStatus: begin
                    if (wdata_q[7]) ovf_d = 1'b0;
                    if (wdata_q[8]) unf_d = 1'b0;
                end
                RegIrqCtrl: irq_ctrl_d = wdata_q[1:0];
            endcase
        end
        if (rd_en && (sel_q == RegFifo)) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                count_d  = count_q - CntW'(1);
            end
        end
        // Built from next-state values so the line follows the cause by exactly one cycle.
        irq_d = (irq_ctrl_d[0] && (count_d != '0)) || (irq_ctrl_d[1] && (ovf_d || unf_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q     <= '0;
            rw_q       <= 1'b0;
            sel_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            scratch_q  <= '0;
            irq_ctrl_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            if (accept) begin
                rw_q    <= io_bus.io_rw;
                sel_q   <= io_bus.io_address[2:1];
                be_q    <= io_bus.io_byte_enable;
                wdata_q <= io_bus.io_write_data;
            end
            scratch_q  <= scratch_d;
            irq_ctrl_q <= irq_ctrl_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_q;
        end
    end
endmodule
